// File: rtl/game_flow_ctl.sv
// Purpose: top-level phase sequencer for the two-player tower game (screens, sync, countdown, levels, tx/rx control bytes).
// Latency: inputs act one cycle after their sampling edge (keys/vsync add one cycle for edge detect); all outputs registered.
// Backpressure: tx_valid/tx_byte hold until tx_ready; requests queue as pending flags (DIED > EXIT > READY), one byte in flight.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   vsync                frame tick source (rising edge)
//   key_enter, key_space keyboard levels, rising-edge detected
//   player_exit/hazard   local figure status levels
//   rx_valid, rx_byte    one-cycle strobe + byte from peer
//   tx_ready/valid/byte  byte link towards peer
//   screen_sel, game_run, level, countdown, player_reset  to draw/move datapath
module game_flow_ctl #(
  parameter int FPS                 = 60,
  parameter int COUNTDOWN_S         = 3,
  parameter int CLEAR_FRAMES        = 120,
  parameter int NUM_LEVELS          = 4,
  parameter int PEER_TIMEOUT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       key_enter,
  input  logic       key_space,
  input  logic       player_exit,
  input  logic       player_hazard,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  output logic [1:0] screen_sel,
  output logic       game_run,
  output logic [2:0] level,
  output logic [1:0] countdown,
  output logic       player_reset
);

  localparam logic [7:0] MSG_READY = 8'hA5;
  localparam logic [7:0] MSG_EXIT  = 8'h5A;
  localparam logic [7:0] MSG_DIED  = 8'h3C;

  // One shared frame counter serves timeout, countdown seconds and clear time.
  localparam int CNT_A   = (FPS > CLEAR_FRAMES) ? FPS : CLEAR_FRAMES;
  localparam int CNT_MAX = (CNT_A > PEER_TIMEOUT_FRAMES) ? CNT_A : PEER_TIMEOUT_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PEER, S_COUNTDOWN, S_PLAY, S_LEVEL_CLEAR, S_WIN, S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic            enter_q, enter_d, enter_prev_q, enter_prev_d;
  logic            space_q, space_d, space_prev_q, space_prev_d;
  logic            peer_ready_q, peer_ready_d;
  logic            local_exit_q, local_exit_d;
  logic            peer_exit_q, peer_exit_d;
  logic            pend_ready_q, pend_ready_d;
  logic            pend_exit_q, pend_exit_d;
  logic            pend_died_q, pend_died_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [2:0]      level_q, level_d;
  logic [1:0]      countdown_q, countdown_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            player_reset_q, player_reset_d;
  logic [1:0]      screen_sel_q, screen_sel_d;
  logic            game_run_q, game_run_d;

  logic frame_tick, enter_edge, space_edge;
  logic rx_is_ready, rx_is_exit, rx_is_died;
  logic req_ready, req_exit, req_died;

  always_comb begin
    // defaults: hold everything, pulse outputs low
    state_d        = state_q;
    vsync_d        = vsync;
    vsync_prev_d   = vsync_q;
    enter_d        = key_enter;
    enter_prev_d   = enter_q;
    space_d        = key_space;
    space_prev_d   = space_q;
    peer_ready_d   = peer_ready_q;
    local_exit_d   = local_exit_q;
    peer_exit_d    = peer_exit_q;
    pend_ready_d   = pend_ready_q;
    pend_exit_d    = pend_exit_q;
    pend_died_d    = pend_died_q;
    tx_valid_d     = tx_valid_q;
    tx_byte_d      = tx_byte_q;
    level_d        = level_q;
    countdown_d    = countdown_q;
    frame_cnt_d    = frame_cnt_q;
    player_reset_d = 1'b0;
    screen_sel_d   = 2'd1;
    game_run_d     = 1'b0;
    req_ready      = 1'b0;
    req_exit       = 1'b0;
    req_died       = 1'b0;

    frame_tick  = vsync_q & ~vsync_prev_q;
    enter_edge  = enter_q & ~enter_prev_q;
    space_edge  = space_q & ~space_prev_q;
    rx_is_ready = rx_valid && (rx_byte == MSG_READY);
    rx_is_exit  = rx_valid && (rx_byte == MSG_EXIT);
    rx_is_died  = rx_valid && (rx_byte == MSG_DIED);

    case (state_q)
      S_IDLE: begin
        // enter wins over a simultaneous space edge (space is not used here)
        if (enter_edge) begin
          req_ready    = 1'b1;
          peer_ready_d = 1'b0;
          frame_cnt_d  = '0;
          state_d      = S_WAIT_PEER;
        end else if (rx_is_ready) begin
          peer_ready_d = 1'b1;
        end
      end
      S_WAIT_PEER: begin
        if (peer_ready_q || rx_is_ready) begin
          state_d = S_COUNTDOWN;
        end else if (frame_tick) begin
          if (frame_cnt_q == CW'(PEER_TIMEOUT_FRAMES - 1)) state_d = S_IDLE;
          else frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == CW'(FPS - 1)) begin
            frame_cnt_d = '0;
            if (countdown_q == 2'd1) begin
              countdown_d = 2'd0;
              state_d     = S_PLAY;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // hazard is checked first so a same-cycle exit never sends EXIT
        if (player_hazard) begin
          req_died = 1'b1;
          state_d  = S_LOSE;
        end else if (rx_is_died) begin
          state_d = S_LOSE;
        end else begin
          if (player_exit && !local_exit_q) begin
            local_exit_d = 1'b1;
            req_exit     = 1'b1;
          end
          if (rx_is_exit) peer_exit_d = 1'b1;
          if (local_exit_d && peer_exit_d) state_d = S_LEVEL_CLEAR;
        end
      end
      S_LEVEL_CLEAR: begin
        if (frame_tick) begin
          if (frame_cnt_q == CW'(CLEAR_FRAMES - 1)) begin
            if (level_q == 3'(NUM_LEVELS - 1)) begin
              state_d = S_WIN;
            end else begin
              level_d      = level_q + 3'd1;
              local_exit_d = 1'b0;
              peer_exit_d  = 1'b0;
              state_d      = S_COUNTDOWN;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (space_edge) begin
          state_d      = S_IDLE;
          level_d      = 3'd0;
          peer_ready_d = 1'b0;
          local_exit_d = 1'b0;
          peer_exit_d  = 1'b0;
        end else if (rx_is_ready) begin
          peer_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // state entry actions
    if (state_d == S_COUNTDOWN && state_q != S_COUNTDOWN) begin
      countdown_d    = 2'(COUNTDOWN_S);
      frame_cnt_d    = '0;
      player_reset_d = 1'b1;
    end
    if (state_d == S_LEVEL_CLEAR && state_q != S_LEVEL_CLEAR) frame_cnt_d = '0;

    // pending requests; setting an already-set flag changes nothing
    if (req_ready) pend_ready_d = 1'b1;
    if (req_exit)  pend_exit_d  = 1'b1;
    if (req_died)  pend_died_d  = 1'b1;

    // tx slot: load from flags registered last cycle, only when empty
    if (tx_valid_q) begin
      if (tx_ready) tx_valid_d = 1'b0;
    end else if (pend_died_q) begin
      tx_byte_d   = MSG_DIED;
      tx_valid_d  = 1'b1;
      pend_died_d = 1'b0;
    end else if (pend_exit_q) begin
      tx_byte_d   = MSG_EXIT;
      tx_valid_d  = 1'b1;
      pend_exit_d = 1'b0;
    end else if (pend_ready_q) begin
      tx_byte_d    = MSG_READY;
      tx_valid_d   = 1'b1;
      pend_ready_d = 1'b0;
    end

    // entering IDLE drops queued requests; an in-flight byte still completes
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      pend_ready_d = 1'b0;
      pend_exit_d  = 1'b0;
      pend_died_d  = 1'b0;
    end

    // outputs registered from next state so they line up with state_q
    case (state_d)
      S_COUNTDOWN, S_LEVEL_CLEAR: screen_sel_d = 2'd0;
      S_PLAY: begin
        screen_sel_d = 2'd0;
        game_run_d   = 1'b1;
      end
      S_WIN:   screen_sel_d = 2'd2;
      S_LOSE:  screen_sel_d = 2'd3;
      default: screen_sel_d = 2'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      vsync_q        <= 1'b0;
      vsync_prev_q   <= 1'b0;
      enter_q        <= 1'b0;
      enter_prev_q   <= 1'b0;
      space_q        <= 1'b0;
      space_prev_q   <= 1'b0;
      peer_ready_q   <= 1'b0;
      local_exit_q   <= 1'b0;
      peer_exit_q    <= 1'b0;
      pend_ready_q   <= 1'b0;
      pend_exit_q    <= 1'b0;
      pend_died_q    <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_byte_q      <= 8'h00;
      level_q        <= 3'd0;
      countdown_q    <= 2'd0;
      frame_cnt_q    <= '0;
      player_reset_q <= 1'b0;
      screen_sel_q   <= 2'd1;
      game_run_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync_d;
      vsync_prev_q   <= vsync_prev_d;
      enter_q        <= enter_d;
      enter_prev_q   <= enter_prev_d;
      space_q        <= space_d;
      space_prev_q   <= space_prev_d;
      peer_ready_q   <= peer_ready_d;
      local_exit_q   <= local_exit_d;
      peer_exit_q    <= peer_exit_d;
      pend_ready_q   <= pend_ready_d;
      pend_exit_q    <= pend_exit_d;
      pend_died_q    <= pend_died_d;
      tx_valid_q     <= tx_valid_d;
      tx_byte_q      <= tx_byte_d;
      level_q        <= level_d;
      countdown_q    <= countdown_d;
      frame_cnt_q    <= frame_cnt_d;
      player_reset_q <= player_reset_d;
      screen_sel_q   <= screen_sel_d;
      game_run_q     <= game_run_d;
    end
  end

  assign tx_valid     = tx_valid_q;
  assign tx_byte      = tx_byte_q;
  assign screen_sel   = screen_sel_q;
  assign game_run     = game_run_q;
  assign level        = level_q;
  assign countdown    = countdown_q;
  assign player_reset = player_reset_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Purpose: directed bench for game_flow_ctl; tx bytes checked against a scoreboard queue.
// Latency: inputs are driven 1 time unit after a rising edge, outputs sampled there or on the falling edge.
// Backpressure: tx_ready driven by the stimulus sequence; the queue front must be held while stalled.
module tb_game_flow_ctl;

  logic       clk = 1'b0;
  logic       rst_n, vsync, key_enter, key_space, player_exit, player_hazard;
  logic       rx_valid, tx_ready, tx_valid, game_run, player_reset;
  logic [7:0] rx_byte, tx_byte;
  logic [1:0] screen_sel, countdown;
  logic [2:0] level;

  int         n_pass = 0, n_fail = 0, n_total = 0, pr_count = 0;
  logic [7:0] sb[$];
  logic       stall_prev = 1'b0;

  always #5 clk = ~clk;

  game_flow_ctl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .key_enter(key_enter), .key_space(key_space),
    .player_exit(player_exit), .player_hazard(player_hazard), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .screen_sel(screen_sel), .game_run(game_run), .level(level), .countdown(countdown),
    .player_reset(player_reset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // tx monitor: every valid cycle must show the queue front; pop on handshake
  always @(negedge clk) begin
    logic       has;
    logic [7:0] exp;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("tx_hold_valid", 32'(tx_valid), 32'd1);
      if (tx_valid) begin
        has = (sb.size() != 0);
        exp = has ? sb[0] : 8'h00;
        check("tx_byte_sb", 32'({1'b1, tx_byte}), 32'({has, exp}));
        if (tx_ready && has) void'(sb.pop_front());
      end
      stall_prev = tx_valid && !tx_ready;
      if (player_reset) pr_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic press_enter();
    key_enter = 1'b1;
    repeat (3) tick();
    key_enter = 1'b0;
    tick();
  endtask

  task automatic press_space();
    key_space = 1'b1;
    repeat (3) tick();
    key_space = 1'b0;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic pulse_exit();
    player_exit = 1'b1;
    tick();
    player_exit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; key_enter = 1'b0; key_space = 1'b0;
    player_exit = 1'b0; player_hazard = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    tx_ready = 1'b0;
    repeat (2) tick();
    check("rst_screen", 32'(screen_sel), 32'd1);
    check("rst_run", 32'(game_run), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_countdown", 32'(countdown), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_preset", 32'(player_reset), 32'd0);
    rst_n = 1'b1;
    tick();

    // sync and countdown
    tx_ready = 1'b1;
    sb.push_back(8'hA5);
    press_enter();
    check("wait_screen", 32'(screen_sel), 32'd1);
    repeat (10) frame();
    send_rx(8'hA5);
    check("cd_entry_screen", 32'(screen_sel), 32'd0);
    check("cd_entry_value", 32'(countdown), 32'd3);
    check("cd_entry_preset", 32'(player_reset), 32'd1);
    check("cd_entry_run", 32'(game_run), 32'd0);
    tick();
    check("cd_preset_width", 32'(player_reset), 32'd0);
    for (int f = 1; f <= 180; f++) begin
      frame();
      if (f == 59 || f == 60 || f == 119 || f == 120 || f == 179 || f == 180) begin
        check("cd_value", 32'(countdown), (f < 60) ? 32'd3 : (f < 120) ? 32'd2 : (f < 180) ? 32'd1 : 32'd0);
        check("cd_run", 32'(game_run), (f >= 180) ? 32'd1 : 32'd0);
      end
    end
    check("cd_preset_count", 32'(pr_count), 32'd1);

    // level clear through every level to WIN
    for (int lvl = 0; lvl < 4; lvl++) begin
      sb.push_back(8'h5A);
      pulse_exit();
      repeat (5) tick();
      pulse_exit();  // figure returns to the door: no second EXIT
      repeat (3) tick();
      check("play_stays", 32'(game_run), 32'd1);
      send_rx(8'h5A);
      check("clr_run", 32'(game_run), 32'd0);
      check("clr_screen", 32'(screen_sel), 32'd0);
      repeat (119) frame();
      check("clr_level_hold", 32'(level), 32'(lvl));
      check("clr_still_clear", 32'(countdown), 32'd0);
      frame();
      if (lvl < 3) begin
        check("next_level", 32'(level), 32'(lvl + 1));
        check("next_cd", 32'(countdown), 32'd3);
        check("next_preset_count", 32'(pr_count), 32'(lvl + 2));
        repeat (180) frame();
        check("next_play", 32'(game_run), 32'd1);
      end else begin
        check("win_screen", 32'(screen_sel), 32'd2);
        check("win_level", 32'(level), 32'd3);
        check("win_run", 32'(game_run), 32'd0);
      end
    end
    press_space();
    check("win_restart_screen", 32'(screen_sel), 32'd1);
    check("win_restart_level", 32'(level), 32'd0);

    // peer timeout: after 600 ticks a READY no longer starts the countdown
    sb.push_back(8'hA5);
    press_enter();
    repeat (600) frame();
    send_rx(8'hA5);
    check("timeout_idle_screen", 32'(screen_sel), 32'd1);
    check("timeout_idle_cd", 32'(countdown), 32'd0);

    // one tick short of timeout: READY still accepted
    sb.push_back(8'hA5);
    press_enter();
    repeat (599) frame();
    send_rx(8'hA5);
    check("pre_timeout_screen", 32'(screen_sel), 32'd0);
    check("pre_timeout_cd", 32'(countdown), 32'd3);
    repeat (180) frame();
    check("pre_timeout_play", 32'(game_run), 32'd1);

    // hazard and exit together with peer_exit set: LOSE, only DIED sent
    send_rx(8'h5A);
    tx_ready = 1'b0;
    sb.push_back(8'h3C);
    player_hazard = 1'b1;
    player_exit   = 1'b1;
    tick();
    player_hazard = 1'b0;
    player_exit   = 1'b0;
    check("lose_screen", 32'(screen_sel), 32'd3);
    check("lose_run", 32'(game_run), 32'd0);
    repeat (5) tick();
    check("died_valid", 32'(tx_valid), 32'd1);
    check("died_byte", 32'(tx_byte), 32'h3C);
    tx_ready = 1'b1;
    repeat (3) tick();
    check("died_done", 32'(tx_valid), 32'd0);

    // restart from LOSE
    press_enter();
    check("lose_enter_ignored", 32'(screen_sel), 32'd3);
    press_space();
    check("lose_restart_screen", 32'(screen_sel), 32'd1);
    check("lose_restart_level", 32'(level), 32'd0);

    // reset in PLAY while EXIT is stalled on the link
    sb.push_back(8'hA5);
    press_enter();
    send_rx(8'hA5);
    repeat (180) frame();
    check("rst_case_play", 32'(game_run), 32'd1);
    tx_ready = 1'b0;
    sb.push_back(8'h5A);
    pulse_exit();
    repeat (2) tick();
    check("rst_case_stalled", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_screen", 32'(screen_sel), 32'd1);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_run", 32'(game_run), 32'd0);
    sb.delete();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    repeat (3) tick();
    check("idle_after_rst_tx", 32'(tx_valid), 32'd0);
    check("preset_total", 32'(pr_count), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
